// File: rtl/sensor_sequencer_pkg.sv
// sensor_sequencer_pkg: shared Signals/StatusFlags types, sequencer state and AUTO_READ start-state constants
package sensor_sequencer_pkg;
  typedef struct packed {
    logic [2:0] sens_config;
    logic       sens_enable;
    logic       sens_read;
    logic       adc_enable;
    logic       adc_read;
    logic       pad;
  } signals_t;

  typedef struct packed {
    logic       conv_complete;
    logic       already_busy;
    logic       unexpected_pause;
    logic       error;
    logic [3:0] pad;
  } status_flags_t;

  typedef enum logic [2:0] {IDLE, SYNC, T1, T2, ADC_WAIT} seq_state_t;

  localparam logic [7:0] AUTO_READ_START_MASK  = 8'h1E;
  localparam logic [7:0] AUTO_READ_START_VALUE = 8'h14;

  function automatic signals_t apply_signals(signals_t cur, logic [7:0] mask, logic [7:0] value);
    return signals_t'(((cur & ~mask) | (value & mask)) & 8'hFE);
  endfunction
endpackage

// File: rtl/sensor_seq_timer.sv
// sensor_seq_timer: loadable down-counter; done is high in the last cycle of a loaded interval
module sensor_seq_timer #(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);
  logic [WIDTH-1:0] count;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else if (load) count <= value;
    else if (count != '0) count <= count - WIDTH'(1);
  assign done = count == WIDTH'(1);
endmodule

// File: rtl/sensor_sequencer.sv
// sensor_sequencer: SET_SIGNAL/AUTO_READ sensor and ADC sequencing with sticky status flags
// Optional ADC wait timeout enabled by defining SENSOR_SEQ_TIMEOUT_EN.
module sensor_sequencer
  import sensor_sequencer_pkg::*;
#(
  parameter int TIMER_WIDTH = 25,
  parameter int ADC_WIDTH   = 16,
  parameter int ADC_TIMEOUT = 1048576
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_set_signal,
  input  logic                   start_auto_read,
  input  logic                   abort,
  input  logic [15:0]            sync_count,
  input  logic [7:0]             sig_mask,
  input  logic [7:0]             sig_value,
  input  logic [TIMER_WIDTH-1:0] timing1,
  input  logic [TIMER_WIDTH-1:0] timing2,
  input  logic                   pause_seen,
  input  logic                   adc_conversion_complete,
  input  logic [ADC_WIDTH-1:0]   adc_value,
  input  logic                   flags_clear,
  output logic [2:0]             sens_config,
  output logic                   sens_enable,
  output logic                   sens_read,
  output logic                   adc_enable,
  output logic                   adc_read,
  output logic                   busy,
  output logic [7:0]             flags,
  output logic [ADC_WIDTH-1:0]   result
);
  if (ADC_TIMEOUT < 1 || ADC_TIMEOUT >= 2**TIMER_WIDTH) begin : g_bad_timeout
    $error("ADC_TIMEOUT does not fit the timer");
  end

  seq_state_t             state;
  signals_t               sig, set_next;
  status_flags_t          fl, fl_set;
  logic                   is_auto, auto_ok, act, raise_adc, capture, timeout;
  logic [15:0]            sync_cnt;
  logic [7:0]             mask_q, value_q;
  logic [TIMER_WIDTH-1:0] t1_len, t2_len, tmr_value;
  logic                   tmr_load, tmr_done;

  sensor_seq_timer #(.WIDTH(TIMER_WIDTH)) u_timer (
    .clk(clk), .rst_n(rst_n), .load(tmr_load), .value(tmr_value), .done(tmr_done)
  );

  assign set_next  = apply_signals(sig, mask_q, value_q);
  assign auto_ok   = (sig & AUTO_READ_START_MASK) == AUTO_READ_START_VALUE;
  assign act       = state == SYNC && sync_cnt == '0;
  assign raise_adc = set_next.adc_read && !sig.adc_read;
  assign capture   = !abort && state == ADC_WAIT && adc_conversion_complete;
`ifdef SENSOR_SEQ_TIMEOUT_EN
  assign timeout   = !abort && state == ADC_WAIT && !adc_conversion_complete && tmr_done;
`else
  assign timeout   = 1'b0;
`endif

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = t1_len;
    if (act && is_auto) tmr_load = 1'b1;
    else if (state == T1 && tmr_done) begin
      tmr_load  = 1'b1;
      tmr_value = t2_len;
    end
`ifdef SENSOR_SEQ_TIMEOUT_EN
    else if ((state == T2 && tmr_done) || (act && !is_auto && raise_adc)) begin
      tmr_load  = 1'b1;
      tmr_value = TIMER_WIDTH'(ADC_TIMEOUT);
    end
`endif
  end

  always_comb begin
    fl_set = '0;
    fl_set.error = timeout || (!abort && state == IDLE &&
                   ((start_set_signal && start_auto_read) || (start_auto_read && !start_set_signal && !auto_ok)));
    fl_set.already_busy     = busy && (abort || start_set_signal || start_auto_read);
    fl_set.unexpected_pause = pause_seen && (state == T1 || state == T2 || state == ADC_WAIT);
    fl_set.conv_complete    = capture;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sig      <= '0;
      fl       <= '0;
      result   <= '0;
      is_auto  <= 1'b0;
      sync_cnt <= '0;
      mask_q   <= '0;
      value_q  <= '0;
      t1_len   <= '0;
      t2_len   <= '0;
    end else begin
      fl <= (flags_clear ? status_flags_t'('0) : fl) | fl_set;
      if (abort) begin
        state        <= IDLE;
        sig.sens_read <= 1'b0;
        sig.adc_read  <= 1'b0;
      end else begin
        case (state)
          IDLE: if ((start_set_signal ^ start_auto_read) && (start_set_signal || auto_ok)) begin
            state    <= SYNC;
            is_auto  <= start_auto_read;
            sync_cnt <= sync_count;
            mask_q   <= sig_mask;
            value_q  <= sig_value;
            t1_len   <= timing1 == '0 ? TIMER_WIDTH'(1) : timing1;
            t2_len   <= timing2 == '0 ? TIMER_WIDTH'(1) : timing2;
          end
          SYNC: if (act) begin
            if (is_auto) begin
              sig.sens_read <= 1'b1;
              state         <= T1;
            end else begin
              sig   <= set_next;
              state <= raise_adc ? ADC_WAIT : IDLE;
            end
          end else if (pause_seen) sync_cnt <= sync_cnt - 16'd1;
          T1: if (tmr_done) begin
            sig.sens_read <= 1'b0;
            state         <= T2;
          end
          T2: if (tmr_done) begin
            sig.adc_read <= 1'b1;
            state        <= ADC_WAIT;
          end
          ADC_WAIT: if (capture || timeout) begin
            if (capture) result <= adc_value;
            sig.adc_read <= 1'b0;
            state        <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign sens_config = sig.sens_config;
  assign sens_enable = sig.sens_enable;
  assign sens_read   = sig.sens_read;
  assign adc_enable  = sig.adc_enable;
  assign adc_read    = sig.adc_read;
  assign busy        = state != IDLE;
  assign flags       = fl;
endmodule
